// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM generator slice.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int PWM_N       = 3;
  localparam int PWM_STEP    = 32;
  localparam int PWM_CNT_W   = 8;
  localparam int PWM_PRESC_W = 8;

endpackage

// File: rtl/pwm_generator_if.sv
// Control/status bundle between the PWM generator and its host.
interface pwm_generator_if import pwm_pkg::*; #(
  parameter int N       = PWM_N,
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PRESC_W = PWM_PRESC_W
);
  logic               en;
  logic [N-1:0]       level;
  logic [N-1:0]       top;
  logic [PRESC_W-1:0] prescale;
  logic               pwm_out;
  logic               period_end;
  logic               busy;
  logic [CNT_W-1:0]   duty_active;

  modport master (
    output en, level, top, prescale,
    input  pwm_out, period_end, busy, duty_active
  );

  modport slave (
    input  en, level, top, prescale,
    output pwm_out, period_end, busy, duty_active
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every prescale+1 clocks, held cleared while i_clear is high.
module pwm_prescaler import pwm_pkg::*; #(
  parameter int PRESC_W = PWM_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_tick
);
  logic [PRESC_W-1:0] r_cnt;
  logic               w_tick;

  // '>=' lets a shrinking prescale end the current count instead of wrapping the counter
  always_comb begin
    if (i_clear) begin
      w_tick = 1'b0;
    end else begin
      w_tick = (r_cnt >= i_prescale);
    end
  end

  // Divider count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

  assign o_tick = w_tick;
endmodule

// File: rtl/pwm_generator.sv
// PWM generator: period of top*STEP ticks, duty min(level,top)*STEP, clean period-aligned stop.
module pwm_generator import pwm_pkg::*; #(
  parameter int N       = PWM_N,
  parameter int STEP    = PWM_STEP,
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PRESC_W = PWM_PRESC_W
) (
  input logic            clk,
  input logic            rst,
  pwm_generator_if.slave io_bus
);
  state_e           r_state;
  state_e           w_next;
  logic [N-1:0]     r_level_sh;
  logic [N-1:0]     r_top_sh;
  logic [CNT_W-1:0] r_phase;
  logic             r_pwm;
  logic             r_period_end;
  logic [CNT_W-1:0] w_duty;
  logic [CNT_W-1:0] w_period_last;
  logic             w_tick;
  logic             w_top_zero;
  logic             w_wrap;
  logic             w_load;
  logic             w_busy;
  logic             w_clear;

  function automatic logic [CNT_W-1:0] duty_ticks(input logic [N-1:0] lvl, input logic [N-1:0] tp);
    logic [N-1:0] m;
    m = (lvl > tp) ? tp : lvl;
    return CNT_W'(m) * CNT_W'(STEP);
  endfunction

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_prescale(io_bus.prescale),
    .o_tick    (w_tick)
  );

  assign w_duty        = duty_ticks(r_level_sh, r_top_sh);
  assign w_period_last = CNT_W'(r_top_sh) * CNT_W'(STEP) - CNT_W'(1);
  assign w_top_zero    = (r_top_sh == {N{1'b0}});
  assign w_wrap        = w_tick && !w_top_zero && (r_phase == w_period_last);
  assign w_load        = ((r_state == IDLE) && io_bus.en) || w_wrap;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; a zero-length period has no boundary to wait for, so stopping is immediate
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = io_bus.en ? RUN : IDLE;
      RUN: begin
        if (!io_bus.en && (w_wrap || w_top_zero)) begin
          w_next = IDLE;
        end else if (!io_bus.en) begin
          w_next = DRAIN;
        end else begin
          w_next = RUN;
        end
      end
      DRAIN: begin
        if (io_bus.en) begin
          w_next = RUN;
        end else if (w_wrap || w_top_zero) begin
          w_next = IDLE;
        end else begin
          w_next = DRAIN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_busy  = 1'b0;
    w_clear = 1'b1;
    case (r_state)
      RUN, DRAIN: begin
        w_busy  = 1'b1;
        w_clear = 1'b0;
      end
      default: begin
        w_busy  = 1'b0;
        w_clear = 1'b1;
      end
    endcase
  end

  // Shadows reload only at start or wrap; phase and the waveform register advance on ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_sh   <= '0;
      r_top_sh     <= '0;
      r_phase      <= '0;
      r_pwm        <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      if (w_load) begin
        r_level_sh <= io_bus.level;
        r_top_sh   <= io_bus.top;
      end
      if (r_state == IDLE) begin
        r_phase      <= '0;
        r_pwm        <= 1'b0;
        r_period_end <= 1'b0;
      end else begin
        r_pwm        <= (r_phase < w_duty);
        r_period_end <= w_wrap;
        if (w_wrap) begin
          r_phase <= '0;
        end else if (w_tick && !w_top_zero) begin
          r_phase <= r_phase + CNT_W'(1);
        end else begin
          r_phase <= r_phase;
        end
      end
    end
  end

  assign io_bus.pwm_out     = r_pwm;
  assign io_bus.period_end  = r_period_end;
  assign io_bus.busy        = w_busy;
  assign io_bus.duty_active = w_duty;
endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: closed-form waveform model checked every cycle, plus literal period checks.
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int N = 3, STEP = 32, CNT_W = 8, PRESC_W = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  pwm_generator_if #(.N(N), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus_if ();

  pwm_generator #(.N(N), .STEP(STEP), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scenario description: en first driven high in cycle m_t0, tick every m_p clocks, fixed top.
  bit m_active = 1'b0;
  int m_t0 = 0, m_p = 1, m_top = 0, m_stop = -1;
  bit en_log [MAXC];
  int lvl_log[MAXC];
  int hi_cnt = 0;
  int hi_q[$];
  int pe_cyc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Duty of period p: the level seen on the edge that opened that period, clamped to top.
  function automatic int duty_of(input int p);
    int lv;
    lv = lvl_log[m_t0 + p * m_p * m_top * STEP];
    return ((lv < m_top) ? lv : m_top) * STEP;
  endfunction

  always @(negedge clk) begin : compare
    int j, tt, ll, ph, e_pwm, e_pe, e_busy, e_duty;
    bit use_duty;
    if (!rst && cyc < MAXC) begin
      en_log[cyc]  = bus_if.en;
      lvl_log[cyc] = int'(bus_if.level);
      tt = m_top * STEP;
      ll = m_p * tt;
      j  = cyc - m_t0 - 1;
      e_pwm = 0; e_pe = 0; e_busy = 0; e_duty = 0; use_duty = 1'b0;
      if (m_active && j >= 0 && (m_stop < 0 || j <= m_stop)) begin
        use_duty = 1'b1;
        e_busy = (m_stop < 0 || j < m_stop) ? 1 : 0;
        if (tt > 0) begin
          if (j >= 1) begin
            ph = ((j - 1) / m_p) % tt;
            e_pwm = (ph < duty_of((j - 1) / ll)) ? 1 : 0;
          end
          e_pe = (j > 0 && (j % ll) == 0) ? 1 : 0;
          e_duty = duty_of(j / ll);
        end
      end
      chk("pwm_out", int'(bus_if.pwm_out), e_pwm);
      chk("period_end", int'(bus_if.period_end), e_pe);
      chk("busy", int'(bus_if.busy), e_busy);
      if (use_duty) chk("duty_active", int'(bus_if.duty_active), e_duty);
      // A stop happens on the first period boundary (every cycle when top=0) that sees en low
      if (m_active && j >= 0 && m_stop < 0 && !en_log[cyc]) begin
        if (tt == 0) m_stop = j + 1;
        else if (((j + 1) % ll) == 0) m_stop = j + 1;
      end
      if (m_active) begin
        hi_cnt += int'(bus_if.pwm_out);
        if (bus_if.period_end) begin
          hi_q.push_back(hi_cnt);
          pe_cyc_q.push_back(cyc);
          hi_cnt = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int lvl, input int tp, input int ps);
    bus_if.level    = N'(lvl);
    bus_if.top      = N'(tp);
    bus_if.prescale = PRESC_W'(ps);
    m_t0 = cyc; m_p = ps + 1; m_top = tp; m_stop = -1;
    hi_cnt = 0; hi_q.delete(); pe_cyc_q.delete();
    m_active = 1'b1;
    bus_if.en = 1'b1;
  endtask

  task automatic finish_run();
    int k;
    bus_if.en = 1'b0;
    k = 0;
    while (!(m_stop >= 0 && (cyc - m_t0 - 1) > m_stop + 1) && k < 4000) begin
      step(1);
      k++;
    end
    chk("drain_done", (m_stop >= 0) ? 1 : 0, 1);
    m_active = 1'b0;
    chk("idle_busy", int'(bus_if.busy), 0);
    chk("idle_pwm", int'(bus_if.pwm_out), 0);
  endtask

  function automatic int spacing(input int i);
    return pe_cyc_q[i] - pe_cyc_q[i-1];
  endfunction

  initial begin
    bus_if.en = 1'b0; bus_if.level = '0; bus_if.top = '0; bus_if.prescale = '0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_pwm", int'(bus_if.pwm_out), 0);
    chk("rst_pe", int'(bus_if.period_end), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_duty", int'(bus_if.duty_active), 0);
    step(2);

    // 224-clk period, level 3 -> 5 mid-period, later back to 3, en dropped at phase 50
    start(3, 7, 0);
    step(325);
    chk("A_duty_before_change", int'(bus_if.duty_active), 96);
    bus_if.level = 3'd5;
    step(136);
    chk("A_duty_next_period", int'(bus_if.duty_active), 160);
    step(239);
    bus_if.level = 3'd3;
    step(246);
    finish_run();
    chk("A_periods", hi_q.size(), 5);
    if (hi_q.size() == 5) begin
      chk("A_high0", hi_q[0], 96);
      chk("A_high_changed", hi_q[1], 96);
      chk("A_high_next", hi_q[2], 160);
      chk("A_high_last", hi_q[4], 96);
      chk("A_spacing", spacing(1), 224);
      chk("A_spacing_drain", spacing(4), 224);
    end
    step(3);

    // level above top clamps to 100%
    start(7, 4, 0);
    step(139);
    chk("B_duty", int'(bus_if.duty_active), 128);
    finish_run();
    chk("B_periods", hi_q.size(), 2);
    if (hi_q.size() == 2) begin
      chk("B_high", hi_q[1], 128);
      chk("B_spacing", spacing(1), 128);
    end
    step(3);

    // level 0 never drives high
    start(0, 7, 0);
    step(300);
    finish_run();
    chk("C_periods", hi_q.size(), 2);
    if (hi_q.size() == 2) chk("C_high", hi_q[0] + hi_q[1], 0);
    step(3);

    // top 0: busy but silent, no period_end
    start(5, 0, 0);
    step(60);
    chk("D_busy", int'(bus_if.busy), 1);
    finish_run();
    chk("D_no_period_end", hi_q.size(), 0);
    step(3);

    // prescale 3, drop en then re-raise while draining
    start(3, 7, 3);
    step(997);
    bus_if.en = 1'b0;
    step(200);
    chk("E_busy_in_drain", int'(bus_if.busy), 1);
    bus_if.en = 1'b1;
    step(646);
    finish_run();
    chk("E_periods", hi_q.size(), 3);
    if (hi_q.size() == 3) begin
      chk("E_high", hi_q[1], 384);
      chk("E_spacing_reraise", spacing(1), 896);
      chk("E_spacing", spacing(2), 896);
    end
    step(3);

    // asynchronous reset while driving high
    start(7, 7, 0);
    step(50);
    chk("R_pwm_high", int'(bus_if.pwm_out), 1);
    #2;
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    chk("R_pwm", int'(bus_if.pwm_out), 0);
    chk("R_pe", int'(bus_if.period_end), 0);
    chk("R_busy", int'(bus_if.busy), 0);
    chk("R_duty", int'(bus_if.duty_active), 0);
    bus_if.en = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    chk("R_idle_busy", int'(bus_if.busy), 0);
    chk("R_idle_pwm", int'(bus_if.pwm_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter N, default 3: width of the level and top inputs, matching the duty-select counter output.
REQ-002 SHALL have parameter STEP, default 32: ticks per level step.
REQ-003 SHALL have parameter CNT_W, default 8: phase counter width; STEP*(2^N-1) SHALL fit in CNT_W bits.
REQ-004 SHALL have parameter PRESC_W, default 8: prescaler width.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  run request, level-sensitive.
REQ-008 level  input  N  requested duty level, from the duty-select counter.
REQ-009 top  input  N  level corresponding to 100% duty.
REQ-010 prescale  input  PRESC_W  tick every prescale+1 clk cycles.
REQ-011 pwm_out  output  1  registered PWM waveform.
REQ-012 period_end  output  1  one-clk pulse on the last tick of each period.
REQ-013 busy  output  1  high in RUN or DRAIN.
REQ-014 duty_active  output  CNT_W  duty in ticks for the current period.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, RUN, DRAIN.
REQ-016 IDLE: pwm_out=0; phase and prescaler held at 0.
REQ-017 IDLE -> RUN: when en=1 is sampled; on the same edge, level and top are latched into shadow registers and phase=0.
REQ-018 Period length SHALL be top*STEP ticks; phase counts 0 .. top*STEP-1 on each tick, then wraps to 0.
REQ-019 duty_active SHALL equal min(level,top)*STEP, computed from the shadow values; level>top is clamped to 100%.
REQ-020 top=0: pwm_out SHALL stay 0, period_end SHALL be 0, and the FSM SHALL stay in RUN while en=1.
REQ-021 pwm_out SHALL be registered as (phase < duty_active), giving 1 clk latency from the phase value.
REQ-022 Shadow registers SHALL reload from level/top only at period wrap, so mid-period input changes take effect next period.
REQ-023 period_end SHALL pulse for 1 clk on the tick where the phase wraps.
REQ-024 RUN -> DRAIN: when en=0; the current period SHALL complete unchanged.
REQ-025 DRAIN -> IDLE: at period_end; pwm_out SHALL be 0 on the following clk.
REQ-026 DRAIN -> RUN: when en=1 before period_end, with no phase restart.
REQ-027 prescale SHALL be sampled continuously; a change takes effect from the next tick count.

Reset
REQ-028 On rst: FSM=IDLE; pwm_out=0, period_end=0, busy=0, duty_active=0; phase, prescaler and shadows=0.
REQ-029 rst asserted mid-period SHALL abort immediately; no DRAIN.

Structure
REQ-030 pwm_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and the default N/STEP/CNT_W/PRESC_W constants.
REQ-031 Sub-module pwm_prescaler (clk, rst, clear, prescale -> tick) SHALL generate tick; clear is held high in IDLE.

Verification
REQ-032 rst pulse during RUN, pwm_out=1 -> all outputs 0 within the same cycle; IDLE after release.
REQ-033 prescale=0, top=7, level=3, en=1 -> period 224 clk, pwm_out high 96 clk/period, period_end every 224 clk.
REQ-034 level changed 3->5 at phase 100 -> current period 96 high; next period 160 high; duty_active updates at wrap.
REQ-035 level=0 -> pwm_out constant 0; level=7, top=4 -> 100% high over 128-clk period; top=0 -> pwm_out 0, no period_end.
REQ-036 en dropped at phase 50 (level=3, top=7) -> waveform unchanged to phase 223; period_end; then IDLE, busy=0, pwm_out=0.
REQ-037 prescale=3, top=7, level=3 -> period 896 clk, high 384 clk; en re-raised in DRAIN -> continuous waveform, no glitch.
